// File: rtl/sort_pkg.sv
// rtl/sort_pkg.sv - shared FSM state type and default word/capacity sizes for the sort path
package sort_pkg;

    localparam int SORT_DATA_WIDTH  = 8;
    localparam int SORT_MAX_ENTRIES = 64;

    typedef enum logic [2:0] {
        IDLE,
        COUNT,
        LOAD,
        DISCARD,
        CHECK,
        END
    } sort_state_e;

endpackage

// File: rtl/sort_loader.sv
// rtl/sort_loader.sv - frame parser feeding FIFO words to the sorter (count word, N data words)
// Optional trailing XOR checksum word per frame when SORT_LOADER_CHECKSUM_EN is defined.
module sort_loader
    import sort_pkg::*;
#(
    parameter int DATA_WIDTH  = SORT_DATA_WIDTH,
    parameter int MAX_ENTRIES = SORT_MAX_ENTRIES
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  fifo_empty,
    output logic                  fifo_read_enable,
    input  logic [DATA_WIDTH-1:0] fifo_data,
    output logic                  sort_clear,
    output logic                  sort_valid,
    input  logic                  sort_ready,
    output logic [DATA_WIDTH-1:0] sort_data,
    output logic                  sort_last,
    output logic                  busy,
    output logic                  frame_done,
    output logic                  frame_error
);

`ifdef SORT_LOADER_CHECKSUM_EN
    localparam sort_state_e DATA_DONE = CHECK;
`else
    localparam sort_state_e DATA_DONE = END;
`endif

    sort_state_e           state_q, state_d;
    logic [DATA_WIDTH-1:0] remaining_q, remaining_d;
    logic                  inflight_q, inflight_d;
    logic                  hold_valid_q, hold_valid_d;
    logic [DATA_WIDTH-1:0] hold_data_q, hold_data_d;
    logic                  frame_error_q, frame_error_d;
`ifdef SORT_LOADER_CHECKSUM_EN
    logic [DATA_WIDTH-1:0] xor_q, xor_d;
`endif

    logic want_word;
    logic handshake;

    assign handshake = hold_valid_q && sort_ready;

    always_comb begin
        state_d       = state_q;
        remaining_d   = remaining_q;
        hold_valid_d  = hold_valid_q;
        hold_data_d   = hold_data_q;
        frame_error_d = frame_error_q;
        want_word     = 1'b0;
`ifdef SORT_LOADER_CHECKSUM_EN
        xor_d         = xor_q;
`endif
        case (state_q)
            IDLE: begin
                want_word = 1'b1;
                if (inflight_q) begin
                    remaining_d   = fifo_data;
                    frame_error_d = 1'b0;
`ifdef SORT_LOADER_CHECKSUM_EN
                    xor_d         = '0;
`endif
                    state_d       = COUNT;
                end
            end
            COUNT: begin
                if (remaining_q == '0) begin
                    state_d = END;
                end else if (remaining_q > DATA_WIDTH'(MAX_ENTRIES)) begin
                    frame_error_d = 1'b1;
                    state_d       = DISCARD;
                end else begin
                    state_d = LOAD;
                end
            end
            LOAD: begin
                want_word = 1'b1;
                if (inflight_q) begin
                    hold_valid_d = 1'b1;
                    hold_data_d  = fifo_data;
                end
                if (handshake) begin
                    hold_valid_d = 1'b0;
                    remaining_d  = remaining_q - DATA_WIDTH'(1);
`ifdef SORT_LOADER_CHECKSUM_EN
                    xor_d        = xor_q ^ hold_data_q;
`endif
                    if (remaining_q == DATA_WIDTH'(1)) begin
                        state_d = DATA_DONE;
                    end
                end
            end
            DISCARD: begin
                want_word = 1'b1;
                if (inflight_q) begin
                    remaining_d = remaining_q - DATA_WIDTH'(1);
                    if (remaining_q == DATA_WIDTH'(1)) begin
                        state_d = DATA_DONE;
                    end
                end
            end
`ifdef SORT_LOADER_CHECKSUM_EN
            CHECK: begin
                want_word = 1'b1;
                if (inflight_q) begin
                    if (fifo_data != xor_q) begin
                        frame_error_d = 1'b1;
                    end
                    state_d = END;
                end
            end
`endif
            END: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // One word outstanding at most: a new pop waits for both the in-flight read and the holding register.
    assign fifo_read_enable = want_word && !reset && !fifo_empty && !inflight_q && !hold_valid_q;
    assign inflight_d       = fifo_read_enable;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= IDLE;
            remaining_q   <= '0;
            inflight_q    <= 1'b0;
            hold_valid_q  <= 1'b0;
            hold_data_q   <= '0;
            frame_error_q <= 1'b0;
`ifdef SORT_LOADER_CHECKSUM_EN
            xor_q         <= '0;
`endif
        end else begin
            state_q       <= state_d;
            remaining_q   <= remaining_d;
            inflight_q    <= inflight_d;
            hold_valid_q  <= hold_valid_d;
            hold_data_q   <= hold_data_d;
            frame_error_q <= frame_error_d;
`ifdef SORT_LOADER_CHECKSUM_EN
            xor_q         <= xor_d;
`endif
        end
    end

    assign sort_clear  = (state_q == COUNT);
    assign frame_done  = (state_q == END);
    assign busy        = (state_q == COUNT) || (state_q == LOAD) ||
                         (state_q == DISCARD) || (state_q == CHECK);
    assign sort_valid  = hold_valid_q;
    assign sort_data   = hold_data_q;
    assign sort_last   = hold_valid_q && (remaining_q == DATA_WIDTH'(1));
    assign frame_error = frame_error_q;

endmodule

// File: tb/tb_sort_loader.sv
// tb/tb_sort_loader.sv - directed bench for sort_loader with an expected-stream scoreboard
module tb_sort_loader;

    localparam int DW   = 8;
    localparam int MAXE = 64;

    logic          clk = 1'b0;
    logic          reset;
    logic          fifo_empty = 1'b1;
    logic          fifo_read_enable;
    logic [DW-1:0] fifo_data = '0;
    logic          sort_clear;
    logic          sort_valid;
    logic          sort_ready;
    logic [DW-1:0] sort_data;
    logic          sort_last;
    logic          busy;
    logic          frame_done;
    logic          frame_error;

    always #5 clk = ~clk;

    sort_loader #(.DATA_WIDTH(DW), .MAX_ENTRIES(MAXE)) dut (
        .clk              (clk),
        .reset            (reset),
        .fifo_empty       (fifo_empty),
        .fifo_read_enable (fifo_read_enable),
        .fifo_data        (fifo_data),
        .sort_clear       (sort_clear),
        .sort_valid       (sort_valid),
        .sort_ready       (sort_ready),
        .sort_data        (sort_data),
        .sort_last        (sort_last),
        .busy             (busy),
        .frame_done       (frame_done),
        .frame_error      (frame_error)
    );

    typedef struct {
        logic [DW-1:0] d;
        logic          last;
    } word_t;

    int            tests = 0;
    int            fails = 0;
    logic [DW-1:0] fq[$];
    logic [DW-1:0] payload[$];
    word_t         exp_w[$];
    logic          exp_err[$];
    int            pops = 0, hs = 0, clears = 0, dones = 0, valid_cnt = 0, cyc = 0;
    int            last_clear = 0, last_done = 0;
    logic [DW-1:0] last_hs_data = '0;
    logic          prev_stall = 1'b0;
    logic [DW-1:0] prev_data = '0;
    logic          prev_last = 1'b0;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    // FIFO with registered read: word appears on fifo_data the cycle after the pop.
    always @(posedge clk) begin
        if (fifo_read_enable && fq.size() > 0) begin
            fifo_data <= fq.pop_front();
            pops++;
        end
        fifo_empty <= (fq.size() == 0);
    end

    task automatic push(input logic [DW-1:0] w);
        fq.push_back(w);
        fifo_empty = 1'b0;
    endtask

    // Expected output: words of good frames in order, and one error verdict per frame.
    task automatic send_frame(input int n, input logic bad_trailer);
        logic          err;
        logic [DW-1:0] x;
        word_t         e;
        err = (n > MAXE);
        x   = '0;
        push(DW'(n));
        for (int i = 0; i < n; i++) begin
            push(payload[i]);
            x = x ^ payload[i];
            if (!err) begin
                e.d    = payload[i];
                e.last = (i == n - 1);
                exp_w.push_back(e);
            end
        end
`ifdef SORT_LOADER_CHECKSUM_EN
        push(bad_trailer ? ~x : x);
        if (bad_trailer) err = 1'b1;
`else
        if (bad_trailer) err = 1'b1;
`endif
        exp_err.push_back(err);
    endtask

    always begin
        @(negedge clk);
        #1;
        cyc++;
        if (reset) begin
            prev_stall = 1'b0;
        end else begin
            if (fifo_read_enable) chk("rd_while_empty", fifo_empty, 1'b0);
            if (prev_stall) begin
                chk("stall_valid", sort_valid, 1'b1);
                chk("stall_data", sort_data, prev_data);
                chk("stall_last", sort_last, prev_last);
            end
            if (sort_valid) valid_cnt++;
            if (sort_valid && sort_ready) begin
                if (exp_w.size() == 0) begin
                    chk("unexpected_word", 1'b1, 1'b0);
                end else begin
                    chk("word_data", sort_data, exp_w[0].d);
                    chk("word_last", sort_last, exp_w[0].last);
                    void'(exp_w.pop_front());
                end
                hs++;
                last_hs_data = sort_data;
            end
            if (sort_clear) begin
                clears++;
                last_clear = cyc;
            end
            if (frame_done) begin
                dones++;
                last_done = cyc;
                if (exp_err.size() == 0) begin
                    chk("unexpected_done", 1'b1, 1'b0);
                end else begin
                    chk("done_error", frame_error, exp_err[0]);
                    void'(exp_err.pop_front());
                end
            end
            prev_stall = sort_valid && !sort_ready;
            prev_data  = sort_data;
            prev_last  = sort_last;
        end
    end

    task automatic wait_done(input int target);
        int n;
        n = 0;
        while (dones < target && n < 600) begin
            @(negedge clk);
            n++;
        end
        chk("done_timeout", dones >= target, 1'b1);
        @(negedge clk);
    endtask

    task automatic wait_hs(input int target);
        int n;
        n = 0;
        while (hs < target && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk("hs_timeout", hs >= target, 1'b1);
    endtask

    task automatic wait_valid();
        int n;
        n = 0;
        @(negedge clk);
        while (!sort_valid && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk("valid_timeout", sort_valid, 1'b1);
    endtask

    function automatic logic [31:0] out_vec();
        return {23'd0, fifo_read_enable, sort_clear, sort_valid, sort_last,
                busy, frame_done, frame_error, |sort_data};
    endfunction

    int p0, v0, h0, d0;

    initial begin
        reset      = 1'b1;
        sort_ready = 1'b0;
        repeat (3) @(negedge clk);
        chk("reset_outputs", out_vec(), 32'd0);
        reset = 1'b0;
        repeat (2) @(negedge clk);

        // Frame 3: 9, 2, 7
        sort_ready = 1'b1;
        payload = '{8'd9, 8'd2, 8'd7};
        send_frame(3, 1'b0);
        wait_done(1);
        chk("t1_clears", clears, 1);
        chk("t1_hs", hs, 3);
        chk("t1_last_word", last_hs_data, 8'd7);
        chk("t1_error", frame_error, 1'b0);
        chk("t1_busy_after", busy, 1'b0);

        // Same frame with ready low for 4 cycles on the second word
        p0 = pops;
        send_frame(3, 1'b0);
        wait_hs(4);
        sort_ready = 1'b0;
        wait_valid();
        repeat (4) @(negedge clk);
        sort_ready = 1'b1;
        wait_done(2);
        chk("t2_hs", hs, 6);
`ifdef SORT_LOADER_CHECKSUM_EN
        chk("t2_pops", pops - p0, 5);
`else
        chk("t2_pops", pops - p0, 4);
`endif
        chk("t2_fifo_drained", fq.size(), 0);

        // Count 0, then frame 1, 5
        v0 = valid_cnt;
        payload.delete();
        send_frame(0, 1'b0);
        wait_done(3);
        chk("t3_clear_to_done", last_done - last_clear, 1);
        chk("t3_no_valid", valid_cnt - v0, 0);
        payload = '{8'h05};
        send_frame(1, 1'b0);
        wait_done(4);
        chk("t3_word5", last_hs_data, 8'h05);

        // Oversized count 65 is discarded
        p0 = pops;
        v0 = valid_cnt;
        payload.delete();
        for (int i = 0; i < 65; i++) payload.push_back(DW'(i * 3 + 1));
        send_frame(65, 1'b0);
        wait_done(5);
`ifdef SORT_LOADER_CHECKSUM_EN
        chk("t4_pops", pops - p0, 67);
`else
        chk("t4_pops", pops - p0, 66);
`endif
        chk("t4_no_valid", valid_cnt - v0, 0);
        chk("t4_error_sticky", frame_error, 1'b1);
        payload = '{8'h11, 8'h22};
        send_frame(2, 1'b0);
        wait_done(6);
        chk("t4_error_cleared", frame_error, 1'b0);
        d0 = 6;

`ifdef SORT_LOADER_CHECKSUM_EN
        payload = '{8'h0F, 8'hF0};
        send_frame(2, 1'b0);
        wait_done(7);
        chk("ck_good", frame_error, 1'b0);
        send_frame(2, 1'b1);
        wait_done(8);
        chk("ck_bad", frame_error, 1'b1);
        d0 = 8;
`endif

        // Reset during second data word of frame 4: 10, 20, 1, 0x33
        h0 = hs;
        push(8'd4);
        push(8'd10);
        push(8'd20);
        push(8'd1);
        push(8'h33);
`ifdef SORT_LOADER_CHECKSUM_EN
        push(8'h33);
`endif
        exp_w.push_back('{8'd10, 1'b0});
        wait_hs(h0 + 1);
        sort_ready = 1'b0;
        wait_valid();
        chk("t5_second_word", sort_data, 8'd20);
        reset = 1'b1;
        exp_w.delete();
        exp_err.delete();
        @(posedge clk);
        #1;
        chk("t5_reset_outputs", out_vec(), 32'd0);
        @(negedge clk);
        reset      = 1'b0;
        sort_ready = 1'b1;
        exp_w.push_back('{8'h33, 1'b1});
        exp_err.push_back(1'b0);
        wait_done(d0 + 1);
        chk("t5_after_reset_word", last_hs_data, 8'h33);
        chk("t5_model_empty", exp_w.size(), 0);
        chk("t5_fifo_drained", fq.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
